// File: rtl/apb_periph_bridge.sv
// ============================================================================
// Module   : apb_periph_bridge
// Brief    : Single-outstanding core-to-APB3 bridge with window check and timeout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_periph_bridge #(
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_START_ADDR = 32'h1A10_0000,
    parameter logic [APB_ADDR_WIDTH-1:0] WIN_END_ADDR   = 32'h1A11_7FFF,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    // A disabled timeout still needs a legal 1-bit counter.
    localparam int             c_CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic           c_TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      w_reject;
    logic                      w_timeout;
    logic                      w_capture;
    logic [APB_DATA_WIDTH-1:0] w_rdata_nxt;
    logic                      w_err_nxt;

    assign w_reject  = (data_addr_i < WIN_START_ADDR) || (data_addr_i > WIN_END_ADDR) ||
                       (data_we_i && (data_be_i != 4'hF));
    // Abort on the edge that ends the TIMEOUT_CYCLES-th unready ACCESS cycle.
    assign w_timeout = c_TO_EN && !pready_i && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        data_gnt_o  = 1'b0;
        w_capture   = 1'b0;
        w_rdata_nxt = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_gnt_o = data_req_i;
                if (data_req_i) begin
                    if (w_reject) begin
                        w_state_nxt = S_RESP;
                        w_capture   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready_i) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                    w_rdata_nxt = pwrite_o ? '0 : prdata_i;
                    w_err_nxt   = pslverr_i;
                end else if (w_timeout) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            // APB strobes follow the next state so they are flop outputs.
            psel_o        <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            penable_o     <= (w_state_nxt == S_ACCESS);
            data_rvalid_o <= (w_state_nxt == S_RESP);
            if (data_gnt_o) begin
                paddr_o  <= data_addr_i;
                pwrite_o <= data_we_i;
                pwdata_o <= data_wdata_i;
            end
            if (w_state_nxt == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !pready_i) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_capture) begin
                data_rdata_o <= w_rdata_nxt;
                data_err_o   <= w_err_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_periph_bridge.sv
// ============================================================================
// Module   : tb_apb_periph_bridge
// Brief    : Directed self-checking bench for apb_periph_bridge (timeout = 16)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_periph_bridge;

    logic        clk;
    logic        rst_n;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int n_tests = 0;
    int n_fail  = 0;

    apb_periph_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .WIN_START_ADDR (32'h1A10_0000),
        .WIN_END_ADDR   (32'h1A11_7FFF),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pwrite_o      (pwrite_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        data_req_i   = 1'b1;
        data_addr_i  = a;
        data_we_i    = we;
        data_wdata_i = wd;
        data_be_i    = be;
    endtask

    // In-window transfer; pready rises on ACCESS cycle waits+1.
    task automatic apb_xfer(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] be, input int waits, input logic slverr,
                            input logic [31:0] prd, input logic exp_err, input logic [31:0] exp_rd);
        req(a, we, wd, be);
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
        #1 chk("xfer_gnt", data_gnt_o, 1'b1);
        tick();
        data_req_i = 1'b0;
        #1 chk("xfer_gnt_busy", data_gnt_o, 1'b0);
        chk("setup_psel", psel_o, 1'b1);
        chk("setup_penable", penable_o, 1'b0);
        chk("setup_paddr", paddr_o, a);
        for (int i = 0; i <= waits; i++) begin
            tick();
            pready_i  = (i == waits);
            pslverr_i = (i == waits) ? slverr : 1'b0;
            prdata_i  = prd;
            chk("access_psel", psel_o, 1'b1);
            chk("access_penable", penable_o, 1'b1);
            chk("access_paddr", paddr_o, a);
            chk("access_pwrite", pwrite_o, we);
            if (we) chk("access_pwdata", pwdata_o, wd);
            chk("access_no_rvalid", data_rvalid_o, 1'b0);
        end
        tick();
        pready_i = 1'b0; pslverr_i = 1'b0;
        chk("resp_rvalid", data_rvalid_o, 1'b1);
        chk("resp_rdata", data_rdata_o, exp_rd);
        chk("resp_err", data_err_o, exp_err);
        chk("resp_psel", psel_o, 1'b0);
        tick();
        chk("resp_rvalid_pulse", data_rvalid_o, 1'b0);
    endtask

    task automatic rejected(input logic [31:0] a, input logic we, input logic [3:0] be);
        req(a, we, 32'hA5A5_A5A5, be);
        #1 chk("rej_gnt", data_gnt_o, 1'b1);
        tick();
        data_req_i = 1'b0;
        chk("rej_psel", psel_o, 1'b0);
        chk("rej_rvalid", data_rvalid_o, 1'b1);
        chk("rej_err", data_err_o, 1'b1);
        chk("rej_rdata", data_rdata_o, 32'h0);
        tick();
        chk("rej_rvalid_pulse", data_rvalid_o, 1'b0);
        chk("rej_psel_after", psel_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
        data_be_i = 4'h0; data_wdata_i = '0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        repeat (3) tick();
        chk("rst_psel", psel_o, 1'b0);
        chk("rst_penable", penable_o, 1'b0);
        chk("rst_pwrite", pwrite_o, 1'b0);
        chk("rst_rvalid", data_rvalid_o, 1'b0);
        chk("rst_err", data_err_o, 1'b0);
        chk("rst_paddr", paddr_o, 32'h0);
        chk("rst_pwdata", pwdata_o, 32'h0);
        chk("rst_rdata", data_rdata_o, 32'h0);
        chk("rst_gnt", data_gnt_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Zero-wait read, then a write with 3 wait states (prdata must not leak).
        apb_xfer(32'h1A10_1000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001);
        apb_xfer(32'h1A10_3004, 1'b1, 32'h1234_5678, 4'hF, 3, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);

        rejected(32'h1A20_0000, 1'b0, 4'hF);
        rejected(32'h1A10_0000, 1'b1, 4'b0011);
        rejected(32'h1A11_8000, 1'b0, 4'hF);
        rejected(32'h1A0F_FFFC, 1'b0, 4'hF);
        // Window edge with be ignored on reads.
        apb_xfer(32'h1A11_7FFF, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);

        // Timeout: 16 unready ACCESS cycles then abort.
        req(32'h1A10_4000, 1'b0, 32'h0, 4'hF);
        pready_i = 1'b0; prdata_i = 32'h7777_7777;
        #1 chk("to_gnt", data_gnt_o, 1'b1);
        tick();
        data_req_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_psel", psel_o, 1'b1);
            chk("to_penable", penable_o, 1'b1);
        end
        tick();
        chk("to_psel_drop", psel_o, 1'b0);
        chk("to_penable_drop", penable_o, 1'b0);
        chk("to_rvalid", data_rvalid_o, 1'b1);
        chk("to_err", data_err_o, 1'b1);
        chk("to_rdata", data_rdata_o, 32'h0);
        tick();
        // pready on the 16th ACCESS cycle beats the timeout.
        apb_xfer(32'h1A10_4000, 1'b0, 32'h0, 4'hF, 15, 1'b0, 32'h1616_1616, 1'b0, 32'h1616_1616);

        // Slave error with req held: grants at T and T+4 only.
        req(32'h1A10_7000, 1'b0, 32'h0, 4'hF);
        prdata_i = 32'hDEAD_BEEF;
        #1 chk("hold_gnt0", data_gnt_o, 1'b1);
        tick(); #1 chk("hold_gnt1", data_gnt_o, 1'b0);
        tick(); pready_i = 1'b1; pslverr_i = 1'b1;
        #1 chk("hold_gnt2", data_gnt_o, 1'b0);
        tick(); pready_i = 1'b0; pslverr_i = 1'b0;
        #1 chk("hold_gnt3", data_gnt_o, 1'b0);
        chk("slverr_rvalid", data_rvalid_o, 1'b1);
        chk("slverr_err", data_err_o, 1'b1);
        chk("slverr_rdata", data_rdata_o, 32'hDEAD_BEEF);
        tick(); #1 chk("hold_gnt4", data_gnt_o, 1'b1);
        tick(); data_req_i = 1'b0; prdata_i = 32'h0000_0042;
        chk("hold2_psel", psel_o, 1'b1);
        tick(); pready_i = 1'b1;
        tick(); pready_i = 1'b0;
        chk("hold2_rvalid", data_rvalid_o, 1'b1);
        chk("hold2_err", data_err_o, 1'b0);
        chk("hold2_rdata", data_rdata_o, 32'h0000_0042);
        tick();

        // Reset during ACCESS abandons the transfer.
        req(32'h1A10_5000, 1'b0, 32'h0, 4'hF);
        #1 chk("rstx_gnt", data_gnt_o, 1'b1);
        tick(); data_req_i = 1'b0;
        tick(); rst_n = 1'b0;
        chk("rstx_penable_pre", penable_o, 1'b1);
        tick(); rst_n = 1'b1;
        chk("rstx_psel", psel_o, 1'b0);
        chk("rstx_penable", penable_o, 1'b0);
        chk("rstx_rvalid", data_rvalid_o, 1'b0);
        tick();
        chk("rstx_rvalid_late", data_rvalid_o, 1'b0);
        apb_xfer(32'h1A10_2000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h55AA_1234, 1'b0, 32'h55AA_1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
